sd_sector_arbiter: RTL and testbench

- Shares one SD SPI command engine (CMD17 single-block read / CMD24 single-block write) between NREQ requesters.
- Sits between the card-init sequencer, which supplies init_ok and sd_hc, and the bit-level SPI command/response engine; the sector data bus is muxed externally using gnt.
- Handles round-robin arbitration, SDSC/SDHC address translation, per-command timeout and bounded retry.

---
 rtl/sd_sector_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sd_sector_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one SD SPI CMD17/CMD24 engine between NREQ requesters,
// with SDSC/SDHC address translation, timeout and bounded retry. Optional stats: SD_SECTOR_ARBITER_STATS_EN.
module sd_sector_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned GAP_CYCLES     = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_ok,
    input  logic                 sd_hc,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*32-1:0]   req_lba,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 eng_start,
    output logic [5:0]           eng_cmd,
    output logic [31:0]          eng_arg,
    output logic                 eng_abort,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic [7:0]           eng_r1,
    input  logic                 eng_data_err
`ifdef SD_SECTOR_ARBITER_STATS_EN
    ,
    output logic [15:0]          stat_ok,
    output logic [15:0]          stat_fail,
    output logic [15:0]          stat_retry
`endif
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [5:0]  CMD_READ  = 6'd17;
    localparam logic [5:0]  CMD_WRITE = 6'd24;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FINISH} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, win;
    logic            found;
    logic [NREQ-1:0] gnt_d, done_d, err_d;
    logic            wr_q, wr_d, wr_sel;
    logic [31:0]     lba_q, lba_d, lba_sel;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            start_d, abort_d, attempt_fail;
    logic [5:0]      cmd_d;
    logic [31:0]     arg_d;
    logic            addr_ovf;

    // Byte addressing cannot represent sectors at or beyond 4 GiB
    assign addr_ovf = !sd_hc && (lba_q[31:23] != 9'd0);

    // Round-robin scan from ptr, then mux the winner's command fields
    always_comb begin
        found   = 1'b0;
        win     = '0;
        wr_sel  = 1'b0;
        lba_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[PW'((32'(ptr_q) + 32'(k)) % 32'(NREQ))]) begin
                found = 1'b1;
                win   = PW'((32'(ptr_q) + 32'(k)) % 32'(NREQ));
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                wr_sel  = req_write[i];
                lba_sel = req_lba[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt;
        wr_d         = wr_q;
        lba_d        = lba_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        done_d       = '0;
        err_d        = '0;
        start_d      = 1'b0;
        abort_d      = 1'b0;
        cmd_d        = eng_cmd;
        arg_d        = eng_arg;
        attempt_fail = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (init_ok && !eng_busy && found) begin
                    gnt_d   = NREQ'(1) << win;
                    wr_d    = wr_sel;
                    lba_d   = lba_sel;
                    ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (addr_ovf) begin
                    err_d   = gnt;
                    gnt_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    start_d = 1'b1;
                    cmd_d   = wr_q ? CMD_WRITE : CMD_READ;
                    arg_d   = sd_hc ? lba_q : {lba_q[22:0], 9'd0};
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // eng_done takes priority over a coincident timeout
                if (eng_done) begin
                    if (eng_r1 == 8'd0 && !eng_data_err) begin
                        done_d  = gnt;
                        gnt_d   = '0;
                        state_d = S_FINISH;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    abort_d      = 1'b1;
                    attempt_fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (attempt_fail) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        err_d   = gnt;
                        gnt_d   = '0;
                        state_d = S_FINISH;
                    end
                end
            end
            S_GAP: begin
                if (gap_q >= GW'(GAP_CYCLES - 1) && !eng_busy) begin
                    state_d = S_ISSUE;
                end else if (gap_q != '1) begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_FINISH: begin
                retry_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            wr_q      <= 1'b0;
            lba_q     <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            eng_cmd   <= '0;
            eng_arg   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt       <= gnt_d;
            done      <= done_d;
            err       <= err_d;
            wr_q      <= wr_d;
            lba_q     <= lba_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            eng_start <= start_d;
            eng_abort <= abort_d;
            eng_cmd   <= cmd_d;
            eng_arg   <= arg_d;
        end
    end

`ifdef SD_SECTOR_ARBITER_STATS_EN
    logic enter_gap;
    assign enter_gap = (state_q == S_WAIT) && (state_d == S_GAP);

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok    <= '0;
            stat_fail  <= '0;
            stat_retry <= '0;
        end else begin
            if (|done_d && stat_ok != 16'hFFFF)       stat_ok    <= stat_ok + 16'd1;
            if (|err_d && stat_fail != 16'hFFFF)      stat_fail  <= stat_fail + 16'd1;
            if (enter_gap && stat_retry != 16'hFFFF)  stat_retry <= stat_retry + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed self-checking bench for sd_sector_arbiter: grant latency, address rules,
// round-robin order, retry spacing, timeout abort and asynchronous reset.
module tb_sd_sector_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned MAXR = 3;
    localparam int unsigned TMO  = 100;
    localparam int unsigned GAP  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_ok = 1'b0;
    logic              sd_hc = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*32-1:0] req_lba = '0;
    logic [NREQ-1:0]   gnt, done, err;
    logic              eng_start, eng_abort;
    logic [5:0]        eng_cmd;
    logic [31:0]       eng_arg;
    logic              eng_busy = 1'b0;
    logic              eng_done = 1'b0;
    logic [7:0]        eng_r1 = 8'd0;
    logic              eng_data_err = 1'b0;
`ifdef SD_SECTOR_ARBITER_STATS_EN
    logic [15:0]       stat_ok, stat_fail, stat_retry;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    sd_sector_arbiter #(
        .NREQ(NREQ), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_ok(init_ok), .sd_hc(sd_hc),
        .req(req), .req_write(req_write), .req_lba(req_lba),
        .gnt(gnt), .done(done), .err(err),
        .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_arg(eng_arg), .eng_abort(eng_abort),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_r1(eng_r1), .eng_data_err(eng_data_err)
`ifdef SD_SECTOR_ARBITER_STATS_EN
        , .stat_ok(stat_ok), .stat_fail(stat_fail), .stat_retry(stat_retry)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag, output int at);
        int n = 0;
        while (eng_start !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 32'(eng_start), 32'd1);
        at = cyc;
    endtask

    task automatic wait_abort(input string tag, output int at);
        int n = 0;
        while (eng_abort !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_abort_seen"}, 32'(eng_abort), 32'd1);
        at = cyc;
    endtask

    task automatic eng_reply(input logic [7:0] r1, input logic derr);
        eng_r1       = r1;
        eng_data_err = derr;
        eng_done     = 1'b1;
        tick();
        eng_done     = 1'b0;
        eng_r1       = 8'd0;
        eng_data_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t_prev, n_start;
        t_prev = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_start", 32'(eng_start), 32'd0);
        check("rst_abort", 32'(eng_abort), 32'd0);
        check("rst_cmd", 32'(eng_cmd), 32'd0);
        check("rst_arg", eng_arg, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single read, block addressing
        init_ok = 1'b1;
        sd_hc   = 1'b1;
        req_lba = {32'd0, 32'd0, 32'd0, 32'd5};
        req     = 4'b0001;
        tick();
        check("rd_gnt", 32'(gnt), 32'h1);
        check("rd_no_start_yet", 32'(eng_start), 32'd0);
        req = 4'b0000;
        tick();
        check("rd_start", 32'(eng_start), 32'd1);
        check("rd_cmd", 32'(eng_cmd), 32'd17);
        check("rd_arg", eng_arg, 32'd5);
        tick();
        check("rd_start_pulse", 32'(eng_start), 32'd0);
        eng_reply(8'h00, 1'b0);
        check("rd_done", 32'(done), 32'h1);
        check("rd_err", 32'(err), 32'd0);
        check("rd_gnt_drop", 32'(gnt), 32'd0);
        tick();
        check("rd_done_pulse", 32'(done), 32'd0);

        // Write, byte addressing: arg = 3 << 9
        sd_hc     = 1'b0;
        req_lba   = {32'd0, 32'd0, 32'd3, 32'd5};
        req_write = 4'b0010;
        req       = 4'b0010;
        tick();
        check("wr_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        check("wr_start", 32'(eng_start), 32'd1);
        check("wr_cmd", 32'(eng_cmd), 32'd24);
        check("wr_arg", eng_arg, 32'h600);
        eng_reply(8'h00, 1'b0);
        check("wr_done", 32'(done), 32'h2);
        tick();

        // SDSC address overflow: error without a command
        req_lba   = {32'd0, 32'h0080_0000, 32'd3, 32'd5};
        req_write = 4'b0000;
        req       = 4'b0100;
        tick();
        check("ovf_gnt", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("ovf_err", 32'(err), 32'h4);
        check("ovf_done", 32'(done), 32'd0);
        check("ovf_gnt_drop", 32'(gnt), 32'd0);
        n_start = 32'(eng_start);
        repeat (6) begin
            tick();
            if (eng_start) n_start++;
        end
        check("ovf_no_start", 32'(n_start), 32'd0);
        check("ovf_err_pulse", 32'(err), 32'd0);

        // Round robin from ptr=0 with all requests held
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        sd_hc   = 1'b1;
        req_lba = {32'd103, 32'd102, 32'd101, 32'd100};
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start($sformatf("rr%0d", k), t0);
            check($sformatf("rr%0d_gnt", k), 32'(4'b0001 << (k % 4)), 32'(gnt));
            check($sformatf("rr%0d_arg", k), eng_arg, 32'(100 + (k % 4)));
            eng_reply(8'h00, 1'b0);
            check($sformatf("rr%0d_done", k), 32'(done), 32'(4'b0001 << (k % 4)));
        end
        req = 4'b0000;
        tick();
        tick();

        // Persistent R1 error: 4 attempts spaced GAP+2 cycles, then one err
        req = 4'b0001;
        for (int a = 0; a < 4; a++) begin
            wait_start($sformatf("rty%0d", a), t1);
            req = 4'b0000;
            if (a > 0) check($sformatf("rty%0d_spacing", a), 32'(t1 - t_prev), 32'(GAP + 2));
            t_prev = t1;
            eng_reply(8'h04, 1'b0);
            check($sformatf("rty%0d_err", a), 32'(err), (a == 3) ? 32'h1 : 32'h0);
            check($sformatf("rty%0d_done", a), 32'(done), 32'h0);
        end
        tick();
        check("rty_err_pulse", 32'(err), 32'd0);
`ifdef SD_SECTOR_ARBITER_STATS_EN
        check("stat_retry", 32'(stat_retry), 32'd3);
        check("stat_ok", 32'(stat_ok), 32'd5);
        check("stat_fail", 32'(stat_fail), 32'd1);
`endif
        tick();

        // Silent engine: abort TMO cycles after each start, err after 4 attempts
        req = 4'b0001;
        for (int a = 0; a < 4; a++) begin
            wait_start($sformatf("tmo%0d", a), t0);
            req = 4'b0000;
            wait_abort($sformatf("tmo%0d", a), t1);
            check($sformatf("tmo%0d_delay", a), 32'(t1 - t0), 32'(TMO));
            check($sformatf("tmo%0d_err", a), 32'(err), (a == 3) ? 32'h1 : 32'h0);
        end
        tick();
        check("tmo_abort_pulse", 32'(eng_abort), 32'd0);
        tick();

        // Async reset mid-WAIT; held request re-granted from ptr=0
        req_lba = {32'd103, 32'd102, 32'd7, 32'd100};
        req     = 4'b1010;
        wait_start("rstw", t0);
        check("rstw_gnt", 32'(gnt), 32'h2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_async_gnt", 32'(gnt), 32'd0);
        check("rstw_async_start", 32'(eng_start), 32'd0);
        tick();
        check("rstw_no_done", 32'(done), 32'd0);
        check("rstw_no_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstw_regrant", 32'(gnt), 32'h2);
        req = 4'b0000;
        wait_start("rstw2", t0);
        check("rstw2_arg", eng_arg, 32'd7);
        eng_reply(8'h00, 1'b0);
        check("rstw2_done", 32'(done), 32'h2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
